brq_lsu_resp: RTL and testbench

// - Load/store response end of the LSU, producing the rf_wdata_lsu/rf_we_lsu/lsu_resp_valid/lsu_resp_err/fp_load stream that brq_wbu consumes.
// - Tracks one accepted data-memory operation, which may be split into two bus beats when misaligned.
// - Merges the beats, extracts the byte/half/word, sign- or zero-extends, and steers load data to the int or FP RF.

---
 rtl/brq_pkg.sv | 23 ++
 rtl/brq_lsu_rdata_fmt.sv | 53 +++++
 rtl/brq_lsu_resp.sv | 164 ++++++++++++++++
 tb/tb_brq_lsu_resp.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// -----------------------------------------------------------------------------
// brq_pkg
// Shared LSU types and helpers.
//   lsu_type_e      : access size of an LSU op (word / half / byte).
//   lsu_misaligned  : 1 when an access crosses a 32-bit word boundary.
// -----------------------------------------------------------------------------
package brq_pkg;

   // Byte accesses are encoded as 1x, so both 2'b10 and 2'b11 mean byte.
   typedef enum logic [1:0] {
      LSU_W = 2'b00,
      LSU_H = 2'b01,
      LSU_B = 2'b10
   } lsu_type_e;

   // A word at any non-zero offset, or a half at offset 3, spans two words.
   function automatic logic lsu_misaligned(input logic [1:0] lsu_type,
                                           input logic [1:0] addr_lsb);
      return ((lsu_type == 2'b00) && (addr_lsb != 2'b00)) ||
             ((lsu_type == 2'b01) && (addr_lsb == 2'b11));
   endfunction

endpackage

// File: rtl/brq_lsu_rdata_fmt.sv
// -----------------------------------------------------------------------------
// brq_lsu_rdata_fmt
// Combinational load-data formatter. Merges the two beats of a split access,
// extracts the addressed byte/half/word and sign- or zero-extends it.
//   lsu_type_i  : access size (brq_pkg::lsu_type_e encoding, byte = 1x).
//   lsb_i       : addr[1:0] of the access.
//   sign_ext_i  : sign-extend byte/half results.
//   beat1_i     : captured first beat (only meaningful for split accesses).
//   rdata_i     : current (single or final) beat.
//   data_o      : formatted 32-bit load result.
// -----------------------------------------------------------------------------
module brq_lsu_rdata_fmt
   import brq_pkg::*;
#(
   parameter bit SupportMisaligned = 1'b1
) (
   input  logic [1:0]  lsu_type_i,
   input  logic [1:0]  lsb_i,
   input  logic        sign_ext_i,
   input  logic [31:0] beat1_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic        split;
   logic [55:0] merged;
   logic [31:0] word;

   always_comb begin
      split = SupportMisaligned && lsu_misaligned(lsu_type_i, lsb_i);

      // Byte lane view: for a split access the final beat supplies the bytes
      // above the first beat; otherwise the single beat sits in the low lanes.
      // The widest window ever needed starts at byte 3 and spans 4 bytes.
      merged = split ? {rdata_i[23:0], beat1_i} : {24'b0, rdata_i};

      unique case (lsb_i)
         2'd0:    word = merged[31:0];
         2'd1:    word = merged[39:8];
         2'd2:    word = merged[47:16];
         default: word = merged[55:24];
      endcase

      if (lsu_type_i[1]) begin
         data_o = {{24{sign_ext_i & word[7]}}, word[7:0]};
      end else if (lsu_type_i[0]) begin
         data_o = {{16{sign_ext_i & word[15]}}, word[15:0]};
      end else begin
         data_o = word;
      end
   end

endmodule

// File: rtl/brq_lsu_resp.sv
// -----------------------------------------------------------------------------
// brq_lsu_resp
// Response end of the LSU. Tracks one outstanding data-memory op (one or two
// bus beats), merges and formats load data, and produces the write-back
// stream consumed by brq_wbu. Completion is combinational in the final
// rvalid cycle.
//
// Handshake: an op is accepted when lsu_req_i & lsu_ready_o in the same cycle.
// lsu_ready_o is high in IDLE and in the final-beat cycle, so a new op may be
// accepted in the very cycle the previous one completes. Each data_rvalid_i
// outside IDLE is one beat; data_err_i is only meaningful with data_rvalid_i.
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset.
//   lsu_req_i ... lsu_fp_i : op attributes, sampled on acceptance.
//   lsu_ready_o          : op can be accepted this cycle.
//   data_rvalid_i/rdata_i/err_i : bus response beat.
//   rf_wdata_lsu_o       : formatted load data (0 unless rf_we_lsu_o).
//   rf_we_lsu_o          : load completed without error.
//   lsu_resp_valid_o     : final beat of an op (load or store).
//   lsu_resp_err_o       : op completed with an error.
//   fp_load_o            : completing op is an FP load.
//   busy_o               : an op is outstanding.
//   dbg_state_o          : current FSM state, for observation only.
// -----------------------------------------------------------------------------
module brq_lsu_resp
   import brq_pkg::*;
#(
   parameter bit SupportMisaligned = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [1:0]  lsu_type_i,
   input  logic        lsu_sign_ext_i,
   input  logic [1:0]  lsu_addr_lsb_i,
   input  logic        lsu_fp_i,
   output logic        lsu_ready_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   input  logic        data_err_i,
   output logic [31:0] rf_wdata_lsu_o,
   output logic        rf_we_lsu_o,
   output logic        lsu_resp_valid_o,
   output logic        lsu_resp_err_o,
   output logic        fp_load_o,
   output logic        busy_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      WAIT_LAST  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        we_q;
   logic [1:0]  type_q;
   logic [1:0]  lsb_q;
   logic        sign_ext_q;
   logic        fp_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic        new_split;
   logic        misalign_err;
   logic [31:0] fmt_data;

   assign accept    = lsu_req_i & lsu_ready_o;
   assign new_split = SupportMisaligned && lsu_misaligned(lsu_type_i, lsu_addr_lsb_i);

   // Without misaligned support a boundary-crossing op still takes one beat,
   // but is reported as an error.
   assign misalign_err = !SupportMisaligned && lsu_misaligned(type_q, lsb_q);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (lsu_req_i) state_d = new_split ? WAIT_FIRST : WAIT_LAST;
         end
         WAIT_FIRST: begin
            if (data_rvalid_i) state_d = WAIT_LAST;
         end
         WAIT_LAST: begin
            if (data_rvalid_i) begin
               if (lsu_req_i) state_d = new_split ? WAIT_FIRST : WAIT_LAST;
               else           state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------ holding registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q       <= 1'b0;
         type_q     <= 2'b00;
         lsb_q      <= 2'b00;
         sign_ext_q <= 1'b0;
         fp_q       <= 1'b0;
         rdata_q    <= 32'b0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            we_q       <= lsu_we_i;
            type_q     <= lsu_type_i;
            lsb_q      <= lsu_addr_lsb_i;
            sign_ext_q <= lsu_sign_ext_i;
            fp_q       <= lsu_fp_i;
            err_q      <= 1'b0;
         end else if ((state_q == WAIT_FIRST) && data_rvalid_i) begin
            // First-beat error is held until the final beat rather than
            // aborting, so the bus sees both beats consumed.
            rdata_q <= data_rdata_i;
            err_q   <= data_err_i;
         end
      end
   end

   // -------------------------------------------------------- data formatting
   brq_lsu_rdata_fmt #(
      .SupportMisaligned (SupportMisaligned)
   ) u_rdata_fmt (
      .lsu_type_i (type_q),
      .lsb_i      (lsb_q),
      .sign_ext_i (sign_ext_q),
      .beat1_i    (rdata_q),
      .rdata_i    (data_rdata_i),
      .data_o     (fmt_data)
   );

   // -------------------------------------------------------------- outputs
   assign lsu_ready_o      = (state_q == IDLE) | ((state_q == WAIT_LAST) & data_rvalid_i);
   assign busy_o           = (state_q != IDLE);
   assign lsu_resp_valid_o = (state_q == WAIT_LAST) & data_rvalid_i;
   assign lsu_resp_err_o   = lsu_resp_valid_o & (data_err_i | err_q | misalign_err);
   assign rf_we_lsu_o      = lsu_resp_valid_o & ~we_q & ~lsu_resp_err_o;
   assign fp_load_o        = lsu_resp_valid_o & fp_q & ~we_q;
   assign rf_wdata_lsu_o   = rf_we_lsu_o ? fmt_data : 32'b0;
   assign dbg_state_o      = state_q;

   // ----------------------------------------------------------- assertions
   a_req_when_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
      lsu_req_i |-> lsu_ready_o);

   // A response needs an op that was outstanding or accepted the cycle before.
   a_resp_after_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
      lsu_resp_valid_o |-> $past(busy_o | accept));

endmodule

// File: tb/tb_brq_lsu_resp.sv
// -----------------------------------------------------------------------------
// tb_brq_lsu_resp
// Self-checking bench for brq_lsu_resp. Two instances: u_dut with misaligned
// support, u_dut_na without. sel_na routes the shared stimulus to one of them
// and selects which instance's outputs are observed.
// -----------------------------------------------------------------------------
module tb_brq_lsu_resp;

   typedef struct packed {
      logic        ready;
      logic        busy;
      logic        valid;
      logic        err;
      logic        we;
      logic        fp;
      logic [31:0] wdata;
   } obs_t;

   // ------------------------------------------------------- clock / reset
   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   // ----------------------------------------------------------- stimulus
   logic        sel_na;
   logic        req, we, se, fp, rvalid, derr;
   logic [1:0]  ty, lsb;
   logic [31:0] rdata;

   logic        m_req, m_rvalid, n_req, n_rvalid;
   assign m_req    = req    & ~sel_na;
   assign m_rvalid = rvalid & ~sel_na;
   assign n_req    = req    &  sel_na;
   assign n_rvalid = rvalid &  sel_na;

   logic        m_ready, m_we, m_valid, m_err, m_fp, m_busy;
   logic        n_ready, n_we, n_valid, n_err, n_fp, n_busy;
   logic [31:0] m_wdata, n_wdata;
   logic [1:0]  m_dbg, n_dbg;

   brq_lsu_resp #(.SupportMisaligned(1'b1)) u_dut (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .lsu_req_i (m_req), .lsu_we_i (we), .lsu_type_i (ty),
      .lsu_sign_ext_i (se), .lsu_addr_lsb_i (lsb), .lsu_fp_i (fp),
      .lsu_ready_o (m_ready),
      .data_rvalid_i (m_rvalid), .data_rdata_i (rdata), .data_err_i (derr),
      .rf_wdata_lsu_o (m_wdata), .rf_we_lsu_o (m_we),
      .lsu_resp_valid_o (m_valid), .lsu_resp_err_o (m_err),
      .fp_load_o (m_fp), .busy_o (m_busy), .dbg_state_o (m_dbg)
   );

   brq_lsu_resp #(.SupportMisaligned(1'b0)) u_dut_na (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .lsu_req_i (n_req), .lsu_we_i (we), .lsu_type_i (ty),
      .lsu_sign_ext_i (se), .lsu_addr_lsb_i (lsb), .lsu_fp_i (fp),
      .lsu_ready_o (n_ready),
      .data_rvalid_i (n_rvalid), .data_rdata_i (rdata), .data_err_i (derr),
      .rf_wdata_lsu_o (n_wdata), .rf_we_lsu_o (n_we),
      .lsu_resp_valid_o (n_valid), .lsu_resp_err_o (n_err),
      .fp_load_o (n_fp), .busy_o (n_busy), .dbg_state_o (n_dbg)
   );

   obs_t cur;
   assign cur = sel_na ? {n_ready, n_busy, n_valid, n_err, n_we, n_fp, n_wdata}
                       : {m_ready, m_busy, m_valid, m_err, m_we, m_fp, m_wdata};

   // ---------------------------------------------------------- scoreboard
   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [31:0] exp_q[$];

   // Load result from first principles: lay the beats out as 8 consecutive
   // bytes, take the access's bytes starting at lsb, then extend.
   function automatic logic [31:0] model_load(input logic [1:0] t, input logic [1:0] l,
                                              input logic s, input logic [31:0] b1,
                                              input logic [31:0] b2);
      logic [7:0]  mem [8];
      logic [31:0] v;
      int          n;
      for (int i = 0; i < 4; i++) begin
         mem[i]   = b1[8*i +: 8];
         mem[i+4] = b2[8*i +: 8];
      end
      n = (t == 2'b00) ? 4 : (t == 2'b01) ? 2 : 1;
      v = 32'b0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem[int'(l) + i];
      if (s && n < 4 && v[8*n-1])
         for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic int nbytes(input logic [1:0] t);
      return (t == 2'b00) ? 4 : (t == 2'b01) ? 2 : 1;
   endfunction

   // ------------------------------------------------------------- drivers
   // All drivers start and end 1 time unit after a rising edge.
   task automatic issue(input logic w, input logic [1:0] t, input logic [1:0] l,
                        input logic s, input logic f);
      req = 1'b1; we = w; ty = t; lsb = l; se = s; fp = f;
      @(posedge clk_i); #1;
      req = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d, input logic e, output obs_t o);
      rvalid = 1'b1; rdata = d; derr = e;
      #1 o = cur;
      @(posedge clk_i); #1;
      rvalid = 1'b0; derr = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i); #1;
      end
   endtask

   localparam obs_t IdleObs  = '{ready: 1'b1, busy: 1'b0, valid: 1'b0, err: 1'b0,
                                 we: 1'b0, fp: 1'b0, wdata: 32'h0};
   localparam obs_t FirstObs = '{ready: 1'b0, busy: 1'b1, valid: 1'b0, err: 1'b0,
                                 we: 1'b0, fp: 1'b0, wdata: 32'h0};

   // --------------------------------------------------------------- tests
   task automatic test_reset;
      #1;
      checks++;
      if (cur !== IdleObs) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", cur, IdleObs);
      end
      sel_na = 1'b1; #1;
      checks++;
      if (cur !== IdleObs) begin
         failures++;
         $display("FAIL reset_outputs_na got=%h exp=%h", cur, IdleObs);
      end
      sel_na = 1'b0;
   endtask

   task automatic test_load_formats;
      logic [1:0]  t_ty  [6] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01};
      logic [1:0]  t_lsb [6] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3};
      logic        t_se  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic        t_spl [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] t_b1  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h44332211, 32'hAB000000};
      logic [31:0] t_b2  [6] = '{32'hDEADBEEF, 32'h00800000, 32'h00800000,
                                 32'h80010000, 32'h88776655, 32'h000000CD};
      logic [31:0] t_exp [6] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080,
                                 32'hFFFF8001, 32'h55443322, 32'hFFFFCDAB};
      obs_t o, e;
      for (int i = 0; i < 6; i++) begin
         issue(1'b0, t_ty[i], t_lsb[i], t_se[i], 1'b0);
         if (t_spl[i]) begin
            beat(t_b1[i], 1'b0, o);
            checks++;
            if (o !== FirstObs) begin
               failures++;
               $display("FAIL fmt_first_beat[%0d] got=%h exp=%h", i, o, FirstObs);
            end
         end
         beat(t_b2[i], 1'b0, o);
         e = '{ready: 1'b1, busy: 1'b1, valid: 1'b1, err: 1'b0, we: 1'b1, fp: 1'b0,
               wdata: t_exp[i]};
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL fmt_final_beat[%0d] got=%h exp=%h", i, o, e);
         end
      end
   endtask

   task automatic test_split_err;
      obs_t o, e;
      issue(1'b0, 2'b00, 2'd2, 1'b0, 1'b0);
      beat(32'h11111111, 1'b1, o);
      checks++;
      if (o !== FirstObs) begin
         failures++;
         $display("FAIL split_err_first got=%h exp=%h", o, FirstObs);
      end
      beat(32'h22222222, 1'b0, o);
      e = '{ready: 1'b1, busy: 1'b1, valid: 1'b1, err: 1'b1, we: 1'b0, fp: 1'b0,
            wdata: 32'h0};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL split_err_final got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_back_to_back;
      obs_t o, e;
      issue(1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
      // Final beat of the int load and a new FP load in the same cycle.
      rvalid = 1'b1; rdata = 32'h11112222; derr = 1'b0;
      req = 1'b1; we = 1'b0; ty = 2'b00; lsb = 2'd0; se = 1'b0; fp = 1'b1;
      #1 o = cur;
      e = '{ready: 1'b1, busy: 1'b1, valid: 1'b1, err: 1'b0, we: 1'b1, fp: 1'b0,
            wdata: 32'h11112222};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL b2b_first_resp got=%h exp=%h", o, e);
      end
      @(posedge clk_i); #1;
      req = 1'b0; rvalid = 1'b0;
      #1;
      checks++;
      if (cur !== FirstObs) begin
         failures++;
         $display("FAIL b2b_no_bubble got=%h exp=%h", cur, FirstObs);
      end
      beat(32'h33334444, 1'b0, o);
      e = '{ready: 1'b1, busy: 1'b1, valid: 1'b1, err: 1'b0, we: 1'b1, fp: 1'b1,
            wdata: 32'h33334444};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL b2b_fp_resp got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_store;
      obs_t o, e;
      issue(1'b1, 2'b00, 2'd0, 1'b0, 1'b1);
      beat(32'hFFFFFFFF, 1'b0, o);
      e = '{ready: 1'b1, busy: 1'b1, valid: 1'b1, err: 1'b0, we: 1'b0, fp: 1'b0,
            wdata: 32'h0};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL store_resp got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_reset_mid_op;
      obs_t o;
      issue(1'b0, 2'b00, 2'd1, 1'b0, 1'b0);
      rst_ni = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D;
      #1;
      checks++;
      if (cur !== IdleObs) begin
         failures++;
         $display("FAIL reset_mid_op got=%h exp=%h", cur, IdleObs);
      end
      @(posedge clk_i); #1;
      rvalid = 1'b0; rst_ni = 1'b1;
      // A beat arriving after the lost op must not be taken as its response.
      beat(32'h12345678, 1'b0, o);
      checks++;
      if (o !== IdleObs) begin
         failures++;
         $display("FAIL reset_lost_op_beat got=%h exp=%h", o, IdleObs);
      end
   endtask

   task automatic test_spurious;
      obs_t o;
      beat(32'hFFFFFFFF, 1'b1, o);
      checks++;
      if (o !== IdleObs) begin
         failures++;
         $display("FAIL spurious_beat got=%h exp=%h", o, IdleObs);
      end
      #1;
      checks++;
      if (cur !== IdleObs) begin
         failures++;
         $display("FAIL spurious_after got=%h exp=%h", cur, IdleObs);
      end
   endtask

   task automatic test_no_misaligned;
      obs_t o, e;
      sel_na = 1'b1;
      issue(1'b0, 2'b00, 2'd2, 1'b0, 1'b0);
      beat(32'h12345678, 1'b0, o);
      e = '{ready: 1'b1, busy: 1'b1, valid: 1'b1, err: 1'b1, we: 1'b0, fp: 1'b0,
            wdata: 32'h0};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL na_lw_misaligned got=%h exp=%h", o, e);
      end
      issue(1'b0, 2'b01, 2'd3, 1'b0, 1'b0);
      beat(32'h12345678, 1'b0, o);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL na_lh_misaligned got=%h exp=%h", o, e);
      end
      issue(1'b0, 2'b01, 2'd1, 1'b0, 1'b0);
      beat(32'h00ABCD00, 1'b0, o);
      e = '{ready: 1'b1, busy: 1'b1, valid: 1'b1, err: 1'b0, we: 1'b1, fp: 1'b0,
            wdata: 32'h0000ABCD};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL na_lh_inword got=%h exp=%h", o, e);
      end
      #1;
      checks++;
      if (cur !== IdleObs) begin
         failures++;
         $display("FAIL na_idle_after got=%h exp=%h", cur, IdleObs);
      end
      sel_na = 1'b0;
   endtask

   task automatic test_random;
      obs_t        o, e;
      logic        w, s, f, e1, e2, split, err;
      logic [1:0]  t, l;
      logic [31:0] d1, d2, exp_d;
      for (int n = 0; n < 150; n++) begin
         w  = ($urandom_range(0, 3) == 0);
         t  = 2'($urandom_range(0, 3));
         l  = 2'($urandom_range(0, 3));
         s  = 1'($urandom_range(0, 1));
         f  = 1'($urandom_range(0, 1));
         d1 = $urandom;
         d2 = $urandom;
         e1 = ($urandom_range(0, 7) == 0);
         e2 = ($urandom_range(0, 7) == 0);
         split = (int'(l) + nbytes(t) > 4);
         exp_q.push_back(split ? model_load(t, l, s, d1, d2) : model_load(t, l, s, d2, 32'h0));
         issue(w, t, l, s, f);
         idle_cycles($urandom_range(0, 2));
         if (split) begin
            beat(d1, e1, o);
            checks++;
            if (o !== FirstObs) begin
               failures++;
               $display("FAIL rand_first[%0d] got=%h exp=%h", n, o, FirstObs);
            end
            idle_cycles($urandom_range(0, 2));
         end
         beat(d2, e2, o);
         exp_d = exp_q.pop_front();
         err   = e2 | (split & e1);
         e = '{ready: 1'b1, busy: 1'b1, valid: 1'b1, err: err, we: ~w & ~err,
               fp: f & ~w, wdata: (~w & ~err) ? exp_d : 32'h0};
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL rand_final[%0d] ty=%0d lsb=%0d we=%0d got=%h exp=%h",
                     n, t, l, w, o, e);
         end
         idle_cycles($urandom_range(0, 1));
      end
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      sel_na = 1'b0; req = 1'b0; we = 1'b0; ty = 2'b00; lsb = 2'd0; se = 1'b0;
      fp = 1'b0; rvalid = 1'b0; rdata = 32'h0; derr = 1'b0;
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      test_reset();
      test_load_formats();
      test_split_err();
      test_back_to_back();
      test_store();
      test_reset_mid_op();
      test_spurious();
      test_no_misaligned();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
